dm_load_unit: RTL and testbench
===============================

// Module: dm_load_unit
// PURPOSE
//  Load-side counterpart of the MEM-stage store control. Decodes load opcodes in IR_M,
//  runs a req/ack read handshake with a variable-latency data memory, and stalls the
//  pipeline until data returns. Byte/half extraction and sign/zero extension are done here;
//  a registered result is handed to WB for the register-file write.
// PARAMETERS
//  MAX_WAIT  15  cycles in WAIT without rd_ack before timeout abort (1..255)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  IR_M       in   32  instruction in MEM stage
//  addr_M     in   32  effective address from EX/MEM register
//  rd_req     out  1   read request to data memory, level, held until rd_ack
//  rd_addr    out  32  word address {addr[31:2],2'b00}, stable while rd_req=1
//  rd_ack     in   1   memory: rd_data valid this cycle
//  rd_data    in   32  read word, little-endian (byte0 = [7:0])
//  stall      out  1   freeze IF/ID/EX/MEM registers
//  ld_data_W  out  32  extended load result, valid in WB when ld_valid_W=1
//  ld_valid_W out  1   one-cycle pulse: ld_data_W is to be written back
//  ld_err     out  1   one-cycle pulse with ld_valid_W: timeout/misalign abort
// BEHAVIOUR
//  Interface: one clock domain clk; reset synchronous active-high.
//  Decode IR_M[31:26]: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011; else not load.
//  Reset: state=IDLE; rd_req, stall-source, ld_valid_W, ld_err = 0; ld_data_W = 0; wait cnt = 0.
//  FSM IDLE/WAIT/DONE:
//   IDLE: load_M -> latch addr, load type; rd_req<=1; ->WAIT. Else remain; rd_ack ignored.
//   WAIT: rd_ack -> rd_req<=0, buffer <= ext(rd_data); ->DONE.
//         cnt==MAX_WAIT-1 w/o ack -> rd_req<=0, buffer<=0, err flag; ->DONE.
//   DONE: -> IDLE; ld_data_W<=buffer, ld_valid_W<=1, ld_err<=err flag (visible next cycle = WB).
//  stall = load_M & (state!=DONE), combinational. Deasserts exactly in DONE so instruction
//   advances M->W at that edge.
//  Latency: req issued 1 cycle after load enters M; ack in first WAIT cycle -> 3 M cycles total.
//  Back-to-back loads: second load seen in IDLE cycle after DONE; no bubble beyond that.
//  rd_ack in IDLE/DONE (stale/late) ignored. rd_addr/type frozen from IDLE capture, not IR_M.
//  Extraction (sel = addr[1:0]): lb/lbu byte sel, sign/zero ext; lh/lhu half addr[1], sign/zero
//   ext; lw full word. Widths: all ext to 32 bits.
//  Reset mid-WAIT: rd_req drops at the reset edge; no ld_valid_W pulse for the aborted load.
//  ld_valid_W never asserted for non-load instructions.
// CONFIGURATION
//  DM_ALIGN_CHECK_EN defined: in IDLE, lh/lhu with addr[0]=1 or lw with addr[1:0]!=0 ->
//   no rd_req, straight to DONE with buffer=0, err=1 (ld_err pulses in WB).
//  Undefined: low address bits beyond selection ignored (lw ignores [1:0], lh ignores [0]);
//   request always issued.
// STRUCTURE
//  dm_pkg: opcode localparams (LB..LW, plus SB/SH/SW shared with store control), load-type
//   encoding (2-bit size + unsigned bit), FSM state encoding.
//  Sub-module load_ext: combinational (type, sel, word) -> 32-bit extended result.
//  Top: FSM, wait counter, capture registers, WB output register.
// TESTING
//  lw addr 0x10, ack first WAIT cycle, rd_data 0xDEADBEEF -> stall 2 cycles, ld_data_W=0xDEADBEEF, pulse.
//  lb addr 0x13, rd_data 0x80FF0011 -> 0xFFFFFF80; lbu same -> 0x00000080.
//  lh addr 0x12, rd_data 0x9ABC1234 -> 0xFFFF9ABC; lhu addr 0x10 -> 0x00001234.
//  No ack, MAX_WAIT=15 -> rd_req high 15 cycles, then ld_valid_W+ld_err, ld_data_W=0.
//  Reset in 3rd WAIT cycle -> rd_req=0, stall=0 next cycle; later ack ignored, no pulse.
//  DM_ALIGN_CHECK_EN, lw addr 0x11 -> rd_req never high, ld_err=1, ld_data_W=0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared MEM-stage definitions: opcodes, load-type encoding and load FSM states.
// Used by dm_load_unit and load_ext; the alignment check helper serves DM_ALIGN_CHECK_EN builds.
package dm_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [1:0] size;
        logic       is_unsigned;
    } ld_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } ld_state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic ld_type_t decode_ld_type(input logic [5:0] op);
        ld_type_t t;
        t = '{size: SZ_BYTE, is_unsigned: 1'b0};
        case (op)
            OP_LBU: t = '{size: SZ_BYTE, is_unsigned: 1'b1};
            OP_LH:  t = '{size: SZ_HALF, is_unsigned: 1'b0};
            OP_LHU: t = '{size: SZ_HALF, is_unsigned: 1'b1};
            OP_LW:  t = '{size: SZ_WORD, is_unsigned: 1'b0};
            default: t = '{size: SZ_BYTE, is_unsigned: 1'b0};
        endcase
        return t;
    endfunction

    function automatic logic is_misaligned(input ld_type_t t, input logic [1:0] a);
        return ((t.size == SZ_HALF) && a[0]) || ((t.size == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/dm_load_unit_load_ext.sv
// Combinational byte/half/word selection from a little-endian read word,
// followed by sign or zero extension to 32 bits.
module load_ext
    import dm_pkg::*;
(
    input  ld_type_t    ld_type,
    input  logic [1:0]  sel,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (sel)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = sel[1] ? word[31:16] : word[15:0];

        result = word;
        case (ld_type.size)
            SZ_BYTE: result = ld_type.is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_HALF: result = ld_type.is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// MEM-stage load control: req/ack read handshake, pipeline stall, extension and WB result register.
// Optional DM_ALIGN_CHECK_EN aborts misaligned lh/lhu/lw without issuing a request.
module dm_load_unit
    import dm_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] addr_M,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_ack,
    input  logic [31:0] rd_data,
    output logic        stall,
    output logic [31:0] ld_data_W,
    output logic        ld_valid_W,
    output logic        ld_err
);

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    ld_state_t   state;
    ld_state_t   next_state;
    logic [31:0] addr_q;
    ld_type_t    type_q;
    logic [7:0]  cnt;
    logic [31:0] buffer;
    logic        err_q;
    logic [31:0] ext_result;
    logic        load_M;
    logic        misalign_M;
    logic        cnt_last;
    logic        unused_ir_bits;

    assign load_M         = is_load_op(IR_M[31:26]);
    assign cnt_last       = (cnt == CNT_LAST);
    assign unused_ir_bits = ^IR_M[25:0];

`ifdef DM_ALIGN_CHECK_EN
    assign misalign_M = is_misaligned(decode_ld_type(IR_M[31:26]), addr_M[1:0]);
`else
    assign misalign_M = 1'b0;
`endif

    // Extraction runs on the captured type/address so IR_M may change freely during WAIT.
    load_ext u_load_ext (
        .ld_type (type_q),
        .sel     (addr_q[1:0]),
        .word    (rd_data),
        .result  (ext_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= 32'h0;
            type_q     <= '0;
            cnt        <= 8'h0;
            buffer     <= 32'h0;
            err_q      <= 1'b0;
            ld_data_W  <= 32'h0;
            ld_valid_W <= 1'b0;
            ld_err     <= 1'b0;
        end else begin
            state      <= next_state;
            ld_valid_W <= 1'b0;
            ld_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_M) begin
                        addr_q <= addr_M;
                        type_q <= decode_ld_type(IR_M[31:26]);
                        cnt    <= 8'h0;
                        buffer <= 32'h0;
                        err_q  <= misalign_M;
                    end
                end
                S_WAIT: begin
                    if (rd_ack) begin
                        buffer <= ext_result;
                        err_q  <= 1'b0;
                    end else if (cnt_last) begin
                        buffer <= 32'h0;
                        err_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                S_DONE: begin
                    ld_data_W  <= buffer;
                    ld_valid_W <= 1'b1;
                    ld_err     <= err_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (load_M) next_state = misalign_M ? S_DONE : S_WAIT;
            S_WAIT: if (rd_ack || cnt_last) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Request is exactly the WAIT state, so it drops on the ack/timeout edge and on reset.
    always_comb begin
        rd_req  = (state == S_WAIT);
        rd_addr = {addr_q[31:2], 2'b00};
        stall   = load_M && (state != S_DONE);
    end

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed self-checking bench for dm_load_unit (MAX_WAIT = 15).
// Covers the DM_ALIGN_CHECK_EN misalignment case when that macro is defined.
module tb_dm_load_unit;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M;
    logic [31:0] addr_M;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        stall;
    logic [31:0] ld_data_W;
    logic        ld_valid_W;
    logic        ld_err;

    int checks = 0;
    int passed = 0;
    int req_cycles;

    always #5 clk = ~clk;

    dm_load_unit #(.MAX_WAIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .IR_M       (IR_M),
        .addr_M     (addr_M),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .stall      (stall),
        .ld_data_W  (ld_data_W),
        .ld_valid_W (ld_valid_W),
        .ld_err     (ld_err)
    );

    function automatic logic [31:0] make_ir(input logic [5:0] op);
        return {op, 26'h00155AA};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    // One load from IDLE: ack arrives after 'delay' ack-less WAIT cycles.
    task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input int delay, input logic [31:0] expected);
        IR_M    = make_ir(op);
        addr_M  = addr;
        rd_ack  = 1'b0;
        rd_data = 32'h0;
        #1;
        checkOutput({tag, ".stall_idle"}, 32'(stall), 32'd1);
        checkOutput({tag, ".req_idle"}, 32'(rd_req), 32'd0);
        step();
        checkOutput({tag, ".valid_clear"}, 32'(ld_valid_W), 32'd0);
        for (int i = 0; i < delay; i++) begin
            checkOutput({tag, ".req_wait"}, 32'(rd_req), 32'd1);
            checkOutput({tag, ".stall_wait"}, 32'(stall), 32'd1);
            rd_data = 32'hBAD0BAD0;
            step();
        end
        checkOutput({tag, ".req"}, 32'(rd_req), 32'd1);
        checkOutput({tag, ".rd_addr"}, rd_addr, {addr[31:2], 2'b00});
        rd_ack  = 1'b1;
        rd_data = data;
        step();
        rd_ack  = 1'b0;
        rd_data = 32'hBAD0BAD0;
        #1;
        checkOutput({tag, ".stall_done"}, 32'(stall), 32'd0);
        checkOutput({tag, ".req_done"}, 32'(rd_req), 32'd0);
        step();
        checkOutput({tag, ".valid"}, 32'(ld_valid_W), 32'd1);
        checkOutput({tag, ".data"}, ld_data_W, expected);
        checkOutput({tag, ".err"}, 32'(ld_err), 32'd0);
        IR_M   = make_ir(6'b000000);
        addr_M = 32'h0;
    endtask

    initial begin
        reset   = 1'b1;
        IR_M    = 32'h0;
        addr_M  = 32'h0;
        rd_ack  = 1'b0;
        rd_data = 32'h0;
        step();
        step();
        checkOutput("reset.rd_req", 32'(rd_req), 32'd0);
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.valid", 32'(ld_valid_W), 32'd0);
        checkOutput("reset.err", 32'(ld_err), 32'd0);
        checkOutput("reset.data", ld_data_W, 32'h0);
        reset = 1'b0;
        step();

        applyStimulus("lw", OP_LW, 32'h10, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        applyStimulus("lb13", OP_LB, 32'h13, 32'h80FF0011, 0, 32'hFFFFFF80);
        applyStimulus("lbu13", OP_LBU, 32'h13, 32'h80FF0011, 0, 32'h00000080);
        applyStimulus("lb12", OP_LB, 32'h12, 32'h80FF0011, 1, 32'hFFFFFFFF);
        applyStimulus("lbu12", OP_LBU, 32'h12, 32'h80FF0011, 0, 32'h000000FF);
        applyStimulus("lb10", OP_LB, 32'h10, 32'h80FF0011, 0, 32'h00000011);
        applyStimulus("lh12", OP_LH, 32'h12, 32'h9ABC1234, 2, 32'hFFFF9ABC);
        applyStimulus("lhu10", OP_LHU, 32'h10, 32'h9ABC1234, 0, 32'h00001234);
        applyStimulus("lh10", OP_LH, 32'h10, 32'h9ABC8234, 0, 32'hFFFF8234);
        applyStimulus("lhu12", OP_LHU, 32'h12, 32'h9ABC8234, 3, 32'h00009ABC);

        // Timeout: no ack ever arrives
        IR_M   = make_ir(OP_LW);
        addr_M = 32'h20;
        rd_ack = 1'b0;
        step();
        req_cycles = 0;
        for (int i = 0; i < 40 && rd_req; i++) begin
            req_cycles++;
            step();
        end
        checkOutput("timeout.req_cycles", 32'(req_cycles), 32'd15);
        checkOutput("timeout.stall_done", 32'(stall), 32'd0);
        step();
        checkOutput("timeout.valid", 32'(ld_valid_W), 32'd1);
        checkOutput("timeout.err", 32'(ld_err), 32'd1);
        checkOutput("timeout.data", ld_data_W, 32'h0);
        IR_M = make_ir(6'b000000);
        step();
        checkOutput("timeout.valid_pulse", 32'(ld_valid_W), 32'd0);
        checkOutput("timeout.err_pulse", 32'(ld_err), 32'd0);

        // Reset during the third WAIT cycle, then a late ack
        applyStimulus("pre_reset", OP_LW, 32'h40, 32'h0BADF00D, 0, 32'h0BADF00D);
        IR_M   = make_ir(OP_LW);
        addr_M = 32'h30;
        step();
        step();
        step();
        checkOutput("rst_wait.req_before", 32'(rd_req), 32'd1);
        reset = 1'b1;
        IR_M  = make_ir(6'b000000);
        step();
        checkOutput("rst_wait.req", 32'(rd_req), 32'd0);
        checkOutput("rst_wait.stall", 32'(stall), 32'd0);
        checkOutput("rst_wait.data", ld_data_W, 32'h0);
        reset   = 1'b0;
        rd_ack  = 1'b1;
        rd_data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst_wait.late_ack_valid", 32'(ld_valid_W), 32'd0);
            checkOutput("rst_wait.late_ack_req", 32'(rd_req), 32'd0);
        end
        rd_ack = 1'b0;

        // Store opcode: not a load
        IR_M   = make_ir(OP_SW);
        addr_M = 32'h50;
        #1;
        checkOutput("store.stall", 32'(stall), 32'd0);
        step();
        checkOutput("store.req", 32'(rd_req), 32'd0);
        step();
        checkOutput("store.valid", 32'(ld_valid_W), 32'd0);
        IR_M = make_ir(6'b000000);

`ifdef DM_ALIGN_CHECK_EN
        IR_M   = make_ir(OP_LW);
        addr_M = 32'h11;
        #1;
        checkOutput("misalign.stall_idle", 32'(stall), 32'd1);
        checkOutput("misalign.req_idle", 32'(rd_req), 32'd0);
        step();
        checkOutput("misalign.req_done", 32'(rd_req), 32'd0);
        checkOutput("misalign.stall_done", 32'(stall), 32'd0);
        step();
        checkOutput("misalign.valid", 32'(ld_valid_W), 32'd1);
        checkOutput("misalign.err", 32'(ld_err), 32'd1);
        checkOutput("misalign.data", ld_data_W, 32'h0);
        IR_M = make_ir(6'b000000);
`else
        applyStimulus("lw_unaligned", OP_LW, 32'h11, 32'hCAFEF00D, 0, 32'hCAFEF00D);
`endif
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
